// File: rtl/naive_bus_arb_pkg.sv
// Shared types and helpers for the naive_bus master arbiter.
// Index type is sized for the largest supported master count.
// next_idx wraps by explicit compare so non-power-of-2 counts work.
package naive_bus_arb_pkg;

   localparam int N_MASTER_MAX = 8;
   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int BE_W         = 4;

   typedef logic [2:0] mst_idx_t;

   // Modulo-n increment of a master index.
   function automatic mst_idx_t next_idx(input mst_idx_t idx, input int n);
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/naive_bus_arbiter_if.sv
// naive_bus: split read/write request-grant bus with 1-cycle read return.
// master modport issues requests; slave modport grants and returns data.
// Grants are combinational; a request is accepted when req & gnt.
interface naive_bus;
   import naive_bus_arb_pkg::*;

   logic              rd_req;
   logic              rd_gnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [BE_W-1:0]   rd_be;
   logic [DATA_W-1:0] rd_data;

   logic              wr_req;
   logic              wr_gnt;
   logic [ADDR_W-1:0] wr_addr;
   logic [BE_W-1:0]   wr_be;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output rd_req, rd_addr, rd_be,
      input  rd_gnt, rd_data,
      output wr_req, wr_addr, wr_be, wr_data,
      input  wr_gnt
   );

   modport slave (
      input  rd_req, rd_addr, rd_be,
      output rd_gnt, rd_data,
      input  wr_req, wr_addr, wr_be, wr_data,
      output wr_gnt
   );

endinterface

// File: rtl/naive_bus_arbiter_rr_pick.sv
// Purpose: combinational winner search over a request vector (NAIVE_BUS_ARB_RR_EN selects round-robin from i_ptr, else fixed from 0).
// Latency: 0 cycles, pure combinational.
// Backpressure: none here; the caller decides whether the winner is accepted.
module arb_rr_pick
   import naive_bus_arb_pkg::*;
#(
   parameter int N_MASTER = 2
) (
   input  logic [N_MASTER-1:0] i_req,
`ifdef NAIVE_BUS_ARB_RR_EN
   input  mst_idx_t            i_ptr,
`endif
   output logic                o_any,
   output mst_idx_t            o_win
);

   logic [N_MASTER_MAX-1:0] w_req_pad;

   // Scan from the last search position back to the first so the first hit in search order wins.
   always_comb begin
      int v_start;
      int v_pos;
      v_pos     = 0;
      w_req_pad = '0;
      w_req_pad[N_MASTER-1:0] = i_req;
`ifdef NAIVE_BUS_ARB_RR_EN
      v_start   = int'(i_ptr);
`else
      v_start   = 0;
`endif
      o_any     = 1'b0;
      o_win     = '0;
      for (int k = N_MASTER - 1; k >= 0; k--) begin
         v_pos = v_start + k;
         if (v_pos >= N_MASTER) begin
            v_pos = v_pos - N_MASTER;
         end
         if (w_req_pad[mst_idx_t'(v_pos)]) begin
            o_any = 1'b1;
            o_win = mst_idx_t'(v_pos);
         end
      end
   end

endmodule

// File: rtl/naive_bus_arbiter.sv
// Purpose: shares one naive_bus downstream port among N_MASTER masters; NAIVE_BUS_ARB_RR_EN selects round-robin, else fixed priority (index 0 highest).
// Latency: 0-cycle combinational grant; read data routed to its owner 1 cycle after accept.
// Backpressure: downstream gnt=0 passes straight to the winner; pointers hold and nothing is committed.
module naive_bus_arbiter
   import naive_bus_arb_pkg::*;
#(
   parameter int N_MASTER = 2,
   parameter int IDX_W    = $clog2(N_MASTER)
) (
   input  logic     clk,
   input  logic     rst_n,
   naive_bus.slave  s_bus [N_MASTER],
   naive_bus.master m_bus
);

   // Per-master request fields, padded to the maximum count so a 3-bit index is always in range.
   logic [N_MASTER-1:0] w_rd_req;
   logic [N_MASTER-1:0] w_wr_req;
   logic [ADDR_W-1:0]   w_rd_addr [N_MASTER_MAX];
   logic [BE_W-1:0]     w_rd_be   [N_MASTER_MAX];
   logic [ADDR_W-1:0]   w_wr_addr [N_MASTER_MAX];
   logic [BE_W-1:0]     w_wr_be   [N_MASTER_MAX];
   logic [DATA_W-1:0]   w_wr_data [N_MASTER_MAX];

   logic                w_rd_any;
   logic                w_wr_any;
   mst_idx_t            w_rd_win;
   mst_idx_t            w_wr_win;
   logic                w_rd_acc;

   logic                r_rd_owner_vld;
   logic [IDX_W-1:0]    r_rd_owner;

`ifdef NAIVE_BUS_ARB_RR_EN
   mst_idx_t            r_rd_ptr;
   mst_idx_t            r_wr_ptr;
   logic                w_wr_acc;
`endif

   for (genvar g = 0; g < N_MASTER_MAX; g++) begin : g_mst
      if (g < N_MASTER) begin : g_used
         assign w_rd_req[g]  = s_bus[g].rd_req;
         assign w_wr_req[g]  = s_bus[g].wr_req;
         assign w_rd_addr[g] = s_bus[g].rd_addr;
         assign w_rd_be[g]   = s_bus[g].rd_be;
         assign w_wr_addr[g] = s_bus[g].wr_addr;
         assign w_wr_be[g]   = s_bus[g].wr_be;
         assign w_wr_data[g] = s_bus[g].wr_data;

         // Only the current winner sees the downstream grant.
         assign s_bus[g].rd_gnt  = w_rd_any && (w_rd_win == mst_idx_t'(g)) && m_bus.rd_gnt;
         assign s_bus[g].wr_gnt  = w_wr_any && (w_wr_win == mst_idx_t'(g)) && m_bus.wr_gnt;

         // Returning read data goes to the owner of the previous cycle's accept only.
         assign s_bus[g].rd_data = (r_rd_owner_vld && (r_rd_owner == IDX_W'(g))) ?
                                   m_bus.rd_data : '0;
      end else begin : g_pad
         assign w_rd_addr[g] = '0;
         assign w_rd_be[g]   = '0;
         assign w_wr_addr[g] = '0;
         assign w_wr_be[g]   = '0;
         assign w_wr_data[g] = '0;
      end
   end

   arb_rr_pick #(.N_MASTER(N_MASTER)) u_rd_pick (
      .i_req (w_rd_req),
`ifdef NAIVE_BUS_ARB_RR_EN
      .i_ptr (r_rd_ptr),
`endif
      .o_any (w_rd_any),
      .o_win (w_rd_win)
   );

   arb_rr_pick #(.N_MASTER(N_MASTER)) u_wr_pick (
      .i_req (w_wr_req),
`ifdef NAIVE_BUS_ARB_RR_EN
      .i_ptr (r_wr_ptr),
`endif
      .o_any (w_wr_any),
      .o_win (w_wr_win)
   );

   // Downstream request fields follow the winner and are zero when nobody requests.
   assign m_bus.rd_req  = w_rd_any;
   assign m_bus.rd_addr = w_rd_any ? w_rd_addr[w_rd_win] : '0;
   assign m_bus.rd_be   = w_rd_any ? w_rd_be[w_rd_win]   : '0;
   assign m_bus.wr_req  = w_wr_any;
   assign m_bus.wr_addr = w_wr_any ? w_wr_addr[w_wr_win] : '0;
   assign m_bus.wr_be   = w_wr_any ? w_wr_be[w_wr_win]   : '0;
   assign m_bus.wr_data = w_wr_any ? w_wr_data[w_wr_win] : '0;

   assign w_rd_acc = w_rd_any && m_bus.rd_gnt;

   // Remember who owns the read returning next cycle; advance the read pointer past an accepted winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_owner_vld <= 1'b0;
         r_rd_owner     <= '0;
`ifdef NAIVE_BUS_ARB_RR_EN
         r_rd_ptr       <= '0;
`endif
      end else begin
         r_rd_owner_vld <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_owner <= w_rd_win[IDX_W-1:0];
`ifdef NAIVE_BUS_ARB_RR_EN
            r_rd_ptr   <= next_idx(w_rd_win, N_MASTER);
`endif
         end
      end
   end

`ifdef NAIVE_BUS_ARB_RR_EN
   assign w_wr_acc = w_wr_any && m_bus.wr_gnt;

   // Advance the write pointer past an accepted writer; writes have no return path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
      end else if (w_wr_acc) begin
         r_wr_ptr <= next_idx(w_wr_win, N_MASTER);
      end
   end
`endif

endmodule
